// File: rtl/sdram_arb_pkg.sv
// Shared types and sizing helpers for the SDRAM row arbiter.
package sdram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_LOAD,
    WR_PUSH,
    WR_DRAIN,
    RD_LOAD,
    RD_WAIT,
    RD_POP,
    RD_DONE
  } arb_state_t;

  typedef enum logic {
    GR_WR,
    GR_RD
  } grant_t;

  localparam int unsigned DEF_ROW_STRIDE = 16;
  localparam int unsigned DEF_TIMEOUT    = 1023;

  // Bits needed to hold 0..max_val inclusive.
  function automatic int unsigned counter_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  // Row index to word-offset shift; the stride is a power of two.
  function automatic int unsigned stride_shift(input int unsigned stride);
    return (stride < 2) ? 0 : $clog2(stride);
  endfunction

  localparam int unsigned DEF_ROW_SHIFT = stride_shift(DEF_ROW_STRIDE);
  localparam int unsigned DEF_TIMER_W   = counter_width(DEF_TIMEOUT);

endpackage

// File: rtl/sdram_arb_timer.sv
// Saturating wait counter; flags when the FIFO wait budget is used up.
module sdram_arb_timer #(
  parameter int unsigned MAX = 1023,
  parameter int unsigned W   = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired_c
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !expired_c) begin
      count <= count + W'(1);
    end
  end

  assign expired_c = (count == W'(MAX));

endmodule

// File: rtl/sdram_row_arbiter.sv
// Arbitrates the Sdram_Control FIFO port pair between single-word game writes
// and whole-row fetches for the color mapper; returns rows as a parallel buffer.
module sdram_row_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int unsigned       ADDR_W     = 25,
  parameter int unsigned       DATA_W     = 16,
  parameter int unsigned       ROW_WORDS  = 10,
  parameter int unsigned       ROW_STRIDE = DEF_ROW_STRIDE,
  parameter logic [ADDR_W-1:0] ROW_BASE   = '0,
  parameter int unsigned       TIMEOUT    = DEF_TIMEOUT
) (
  input  logic                               Clk,
  input  logic                               Reset,
  input  logic                               wr_req,
  input  logic [ADDR_W-1:0]                  wr_addr,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               wr_ack,
  input  logic                               row_req,
  input  logic [7:0]                         row_num,
  output logic                               row_busy,
  output logic                               row_valid,
  output logic                               row_err,
  output logic [ROW_WORDS-1:0][DATA_W-1:0]   row_data,
  output logic                               sd_wr_load,
  output logic [ADDR_W-1:0]                  sd_wr_addr,
  output logic                               sd_wr,
  output logic [DATA_W-1:0]                  sd_wr_data,
  input  logic [15:0]                        sd_wr_use,
  output logic                               sd_rd_load,
  output logic [ADDR_W-1:0]                  sd_rd_addr,
  output logic                               sd_rd,
  input  logic [DATA_W-1:0]                  sd_rd_data,
  input  logic [15:0]                        sd_rd_use
);

  localparam int unsigned ROW_SHIFT = stride_shift(ROW_STRIDE);
  localparam int unsigned TIMER_W   = counter_width(TIMEOUT);
  localparam int unsigned IDX_W     = counter_width(ROW_WORDS);

  arb_state_t state, next_state;
  grant_t     last_grant;

  logic [IDX_W-1:0] pop_cnt, pop_cnt_d;
  logic [IDX_W-1:0] cap_cnt;
  logic             rd_q;
  logic [ROW_WORDS-1:0][DATA_W-1:0] shadow;
  logic [ROW_WORDS-1:0][DATA_W-1:0] row_next_c;

  logic waiting_c, timer_expired_c;
  logic rd_use_ok_c, wr_empty_c, last_cap_c;
  logic [ADDR_W-1:0] rd_addr_c;

  logic wr_load_d, wr_push_d, rd_load_d, rd_d, busy_d, valid_d, err_d;

  assign rd_use_ok_c = (sd_rd_use >= 16'(ROW_WORDS));
  assign wr_empty_c  = (sd_wr_use == 16'd0);
  assign last_cap_c  = rd_q && (cap_cnt == IDX_W'(ROW_WORDS - 1));
  assign rd_addr_c   = ROW_BASE + (ADDR_W'(row_num) << ROW_SHIFT);
  assign waiting_c   = (state == WR_DRAIN) || (state == RD_WAIT);

  sdram_arb_timer #(
    .MAX (TIMEOUT),
    .W   (TIMER_W)
  ) u_timer (
    .clk       (Clk),
    .reset     (Reset),
    .clr       (!waiting_c),
    .en        (waiting_c),
    .expired_c (timer_expired_c)
  );

  // Next state plus the values the registered outputs take in that state.
  always_comb begin
    next_state = state;
    wr_load_d  = 1'b0;
    wr_push_d  = 1'b0;
    rd_load_d  = 1'b0;
    rd_d       = 1'b0;
    busy_d     = 1'b0;
    valid_d    = 1'b0;
    err_d      = 1'b0;
    pop_cnt_d  = '0;

    case (state)
      IDLE: begin
        if (row_req && (!wr_req || last_grant == GR_WR)) begin
          next_state = RD_LOAD;
        end else if (wr_req) begin
          next_state = WR_LOAD;
        end
      end
      // A writer that gives up before its push is simply not served.
      WR_LOAD:  next_state = wr_req ? WR_PUSH : IDLE;
      WR_PUSH:  next_state = WR_DRAIN;
      WR_DRAIN: if (wr_empty_c || timer_expired_c) next_state = IDLE;
      RD_LOAD:  next_state = RD_WAIT;
      RD_WAIT: begin
        if (rd_use_ok_c) begin
          next_state = RD_POP;
        end else if (timer_expired_c) begin
          next_state = RD_DONE;
          err_d      = 1'b1;
        end
      end
      RD_POP:   if (last_cap_c) next_state = RD_DONE;
      RD_DONE:  next_state = IDLE;
      default:  next_state = IDLE;
    endcase

    wr_load_d = (next_state == WR_LOAD);
    wr_push_d = (next_state == WR_PUSH);
    rd_load_d = (next_state == RD_LOAD);
    busy_d    = (next_state == RD_LOAD) || (next_state == RD_WAIT) ||
                (next_state == RD_POP);
    valid_d   = (next_state == RD_DONE);
    // Pops run ahead of captures by one cycle; the last RD_POP cycle only captures.
    rd_d      = (next_state == RD_POP) && (pop_cnt < IDX_W'(ROW_WORDS));
    if (next_state == RD_POP) begin
      pop_cnt_d = pop_cnt + IDX_W'(rd_d);
    end
  end

  // Last word arrives on the same edge the row is published.
  always_comb begin
    row_next_c                = shadow;
    row_next_c[ROW_WORDS - 1] = sd_rd_data;
  end

  // State and strobe registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state      <= IDLE;
      last_grant <= GR_WR;
      sd_wr_load <= 1'b0;
      sd_wr      <= 1'b0;
      wr_ack     <= 1'b0;
      sd_rd_load <= 1'b0;
      sd_rd      <= 1'b0;
      row_busy   <= 1'b0;
      row_valid  <= 1'b0;
      row_err    <= 1'b0;
      pop_cnt    <= '0;
      rd_q       <= 1'b0;
    end else begin
      state      <= next_state;
      sd_wr_load <= wr_load_d;
      sd_wr      <= wr_push_d;
      wr_ack     <= wr_push_d;
      sd_rd_load <= rd_load_d;
      sd_rd      <= rd_d;
      row_busy   <= busy_d;
      row_valid  <= valid_d;
      row_err    <= err_d;
      pop_cnt    <= pop_cnt_d;
      rd_q       <= sd_rd;
      if (wr_push_d) begin
        last_grant <= GR_WR;
      end else if (rd_load_d) begin
        last_grant <= GR_RD;
      end
    end
  end

  // Address/data payload registers, shadow capture and row publication.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sd_wr_addr <= '0;
      sd_wr_data <= '0;
      sd_rd_addr <= '0;
      cap_cnt    <= '0;
      shadow     <= '0;
      row_data   <= '0;
    end else begin
      if (wr_load_d) sd_wr_addr <= wr_addr;
      if (wr_push_d) sd_wr_data <= wr_data;
      if (rd_load_d) sd_rd_addr <= rd_addr_c;

      if (state != RD_POP) begin
        cap_cnt <= '0;
      end else if (rd_q) begin
        cap_cnt         <= cap_cnt + IDX_W'(1);
        shadow[cap_cnt] <= sd_rd_data;
      end

      if ((state == RD_POP) && last_cap_c) begin
        row_data <= row_next_c;
      end
    end
  end

endmodule

// File: tb/tb_sdram_row_arbiter.sv
// Self-checking bench for sdram_row_arbiter with a behavioural SDRAM FIFO model.
module tb_sdram_row_arbiter;

  localparam int unsigned ADDR_W     = 25;
  localparam int unsigned DATA_W     = 16;
  localparam int unsigned ROW_WORDS  = 10;
  localparam int unsigned ROW_STRIDE = 16;
  localparam int unsigned TIMEOUT    = 1023;
  localparam logic [ADDR_W-1:0] ROW_BASE = '0;

  logic                             Clk = 1'b0;
  logic                             Reset = 1'b1;
  logic                             wr_req = 1'b0;
  logic [ADDR_W-1:0]                wr_addr = '0;
  logic [DATA_W-1:0]                wr_data = '0;
  logic                             wr_ack;
  logic                             row_req = 1'b0;
  logic [7:0]                       row_num = '0;
  logic                             row_busy, row_valid, row_err;
  logic [ROW_WORDS-1:0][DATA_W-1:0] row_data;
  logic                             sd_wr_load, sd_wr, sd_rd_load, sd_rd;
  logic [ADDR_W-1:0]                sd_wr_addr, sd_rd_addr;
  logic [DATA_W-1:0]                sd_wr_data;
  logic [15:0]                      sd_wr_use = '0;
  logic [15:0]                      sd_rd_use = '0;
  logic [DATA_W-1:0]                sd_rd_data = '0;

  sdram_row_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROW_WORDS(ROW_WORDS),
    .ROW_STRIDE(ROW_STRIDE), .ROW_BASE(ROW_BASE), .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .row_req(row_req), .row_num(row_num), .row_busy(row_busy),
    .row_valid(row_valid), .row_err(row_err), .row_data(row_data),
    .sd_wr_load(sd_wr_load), .sd_wr_addr(sd_wr_addr), .sd_wr(sd_wr),
    .sd_wr_data(sd_wr_data), .sd_wr_use(sd_wr_use),
    .sd_rd_load(sd_rd_load), .sd_rd_addr(sd_rd_addr), .sd_rd(sd_rd),
    .sd_rd_data(sd_rd_data), .sd_rd_use(sd_rd_use)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  // SDRAM model knobs and observation counters.
  int                fill_delay = 0;
  int                fill_words = ROW_WORDS;
  logic [15:0]       salt = '0;
  int                wr_drain_delay = 4;
  logic [15:0]       rd_fifo[$];
  int                rd_timer = 0;
  logic [ADDR_W-1:0] rd_base = '0;
  bit                have_pend = 0;
  logic [15:0]       pend = '0;
  int                wr_timer = 0;
  int                cyc = 0;
  int                n_rd_load = 0, n_rd = 0, n_wr_load = 0, n_wr = 0, n_ack = 0, n_valid = 0;
  logic [ADDR_W-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [DATA_W-1:0] last_wr_data = '0;
  int                wr_load_cyc = 0, wr_cyc = 0;
  int                grant_log[$];
  bit                last_was_wr = 1'b1;
  logic [DATA_W-1:0] exp_row[ROW_WORDS];

  // Memory content: each word holds its own address, xor a per-fetch salt.
  always @(negedge Clk) begin
    cyc++;
    if (have_pend) begin
      sd_rd_data = pend;
      have_pend  = 0;
    end
    if (sd_rd === 1'b1) begin
      n_rd++;
      if (rd_fifo.size() > 0) begin
        pend      = rd_fifo.pop_front();
        have_pend = 1;
      end
    end
    if (sd_rd_load === 1'b1) begin
      n_rd_load++;
      grant_log.push_back(1);
      last_rd_addr = sd_rd_addr;
      rd_fifo.delete();
      have_pend = 0;
      rd_base   = sd_rd_addr;
      rd_timer  = fill_delay + 1;
    end
    if (rd_timer > 0) begin
      rd_timer--;
      if (rd_timer == 0)
        for (int k = 0; k < fill_words; k++)
          rd_fifo.push_back(16'(rd_base + ADDR_W'(k)) ^ salt);
    end
    sd_rd_use = 16'(rd_fifo.size());
    if (sd_wr_load === 1'b1) begin
      n_wr_load++;
      grant_log.push_back(0);
      last_wr_addr = sd_wr_addr;
      wr_load_cyc  = cyc;
    end
    if (sd_wr === 1'b1) begin
      n_wr++;
      last_wr_data = sd_wr_data;
      wr_cyc       = cyc;
      sd_wr_use    = 16'd1;
      wr_timer     = wr_drain_delay;
    end else if (wr_timer > 0) begin
      wr_timer--;
      if (wr_timer == 0) sd_wr_use = 16'd0;
    end
    if (wr_ack === 1'b1) n_ack++;
    if (row_valid === 1'b1) n_valid++;
  end

  function automatic logic [DATA_W-1:0] exp_word(input int r, input int k, input logic [15:0] s);
    logic [ADDR_W-1:0] a;
    a = ADDR_W'(int'(ROW_BASE) + r * int'(ROW_STRIDE) + k);
    return DATA_W'(a) ^ s;
  endfunction

  function automatic logic [ADDR_W-1:0] row_addr(input int r);
    return ADDR_W'(int'(ROW_BASE) + r * int'(ROW_STRIDE));
  endfunction

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic fetch_row(input int r, input int delay, input int words,
                           input logic [15:0] s, output int lat);
    int  v0, rd0;
    bit  seen, ok;
    logic [ROW_WORDS-1:0][DATA_W-1:0] got;
    fill_delay = delay; fill_words = words; salt = s;
    v0 = n_valid; rd0 = n_rd;
    ok = (words >= int'(ROW_WORDS));
    row_num = 8'(r);
    row_req = 1'b1;
    seen = 0; lat = 0;
    while (!seen && lat < int'(TIMEOUT) + 64) begin
      step(); lat++;
      if (row_valid === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL row_valid_wait: row %0d no row_valid after %0d cycles", r, lat);
    end else begin
      checks++;
      if (row_err !== !ok) begin
        failures++;
        $display("FAIL row_err: got %b expected %b", row_err, !ok);
      end
      checks++;
      if (row_busy !== 1'b0) begin
        failures++;
        $display("FAIL row_busy_at_valid: got %b expected 0", row_busy);
      end
    end
    row_req = 1'b0;
    last_was_wr = 1'b0;
    if (ok) for (int k = 0; k < int'(ROW_WORDS); k++) exp_row[k] = exp_word(r, k, s);
    got = row_data;
    step();
    checks++;
    if (n_valid - v0 != 1) begin
      failures++;
      $display("FAIL row_valid_count: got %0d expected 1", n_valid - v0);
    end
    checks++;
    if (n_rd - rd0 != (ok ? int'(ROW_WORDS) : 0)) begin
      failures++;
      $display("FAIL sd_rd_pulses: got %0d expected %0d", n_rd - rd0, ok ? ROW_WORDS : 0);
    end
    checks++;
    if (last_rd_addr !== row_addr(r)) begin
      failures++;
      $display("FAIL sd_rd_addr: got %0h expected %0h", last_rd_addr, row_addr(r));
    end
    for (int k = 0; k < int'(ROW_WORDS); k++) begin
      checks++;
      if (got[k] !== exp_row[k] || row_data[k] !== exp_row[k]) begin
        failures++;
        $display("FAIL row_data[%0d]: got %0h expected %0h", k, got[k], exp_row[k]);
      end
    end
    step(); step();
  endtask

  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int  a0, l0, w0, lat;
    bit  seen;
    a0 = n_ack; l0 = n_wr_load; w0 = n_wr;
    wr_addr = a; wr_data = d; wr_req = 1'b1;
    seen = 0; lat = 0;
    while (!seen && lat < 20) begin
      step(); lat++;
      if (wr_ack === 1'b1) seen = 1;
    end
    wr_req = 1'b0;
    last_was_wr = 1'b1;
    checks++;
    if (!seen || lat != 2) begin
      failures++;
      $display("FAIL wr_ack_latency: got %0d (seen=%0b) expected 2", lat, seen);
    end
    repeat (10) step();
    checks++;
    if (n_ack - a0 != 1 || n_wr_load - l0 != 1 || n_wr - w0 != 1) begin
      failures++;
      $display("FAIL wr_pulse_counts: ack=%0d load=%0d push=%0d expected 1 each",
               n_ack - a0, n_wr_load - l0, n_wr - w0);
    end
    checks++;
    if (last_wr_addr !== a) begin
      failures++;
      $display("FAIL sd_wr_addr: got %0h expected %0h", last_wr_addr, a);
    end
    checks++;
    if (last_wr_data !== d) begin
      failures++;
      $display("FAIL sd_wr_data: got %0h expected %0h", last_wr_data, d);
    end
    checks++;
    if (wr_cyc != wr_load_cyc + 1) begin
      failures++;
      $display("FAIL wr_order: push cycle %0d load cycle %0d expected push one after load",
               wr_cyc, wr_load_cyc);
    end
  endtask

  task automatic test_reset();
    Reset = 1'b1; wr_req = 1'b1; row_req = 1'b1; row_num = 8'd3;
    wr_addr = 25'h47; wr_data = 16'h1234;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({sd_wr_load, sd_wr, sd_rd_load, sd_rd, wr_ack, row_valid, row_busy, row_err} !== 8'h00) begin
        failures++;
        $display("FAIL reset_strobes: got %b expected 00000000",
                 {sd_wr_load, sd_wr, sd_rd_load, sd_rd, wr_ack, row_valid, row_busy, row_err});
      end
    end
    checks++;
    if (row_data !== '0 || sd_wr_addr !== '0 || sd_rd_addr !== '0 || sd_wr_data !== '0) begin
      failures++;
      $display("FAIL reset_values: row_data=%0h wr_addr=%0h rd_addr=%0h wr_data=%0h expected 0",
               row_data, sd_wr_addr, sd_rd_addr, sd_wr_data);
    end
    wr_req = 1'b0; row_req = 1'b0;
    step();
    Reset = 1'b0;
    step(); step();
    checks++;
    if (n_rd_load + n_rd + n_wr_load + n_wr + n_ack + n_valid != 0) begin
      failures++;
      $display("FAIL reset_no_activity: got %0d pulses expected 0",
               n_rd_load + n_rd + n_wr_load + n_wr + n_ack + n_valid);
    end
    for (int k = 0; k < int'(ROW_WORDS); k++) exp_row[k] = '0;
  endtask

  task automatic test_row_fetch();
    int lat, r;
    fetch_row(3, 5, ROW_WORDS, 16'h0000, lat);
    r = int'($urandom_range(0, 255));
    fetch_row(r, 0, ROW_WORDS, 16'($urandom), lat);
    checks++;
    if (lat != int'(ROW_WORDS) + 4) begin
      failures++;
      $display("FAIL row_latency: got %0d expected %0d", lat, ROW_WORDS + 4);
    end
  endtask

  task automatic test_write();
    do_write(25'h47, 16'hBEEF);
    do_write(ADDR_W'($urandom), 16'($urandom));
  endtask

  task automatic test_round_robin();
    int  wr_done, rd_done, r, nerr, first;
    logic [15:0] s;
    wr_done = 0; rd_done = 0;
    grant_log.delete();
    first = last_was_wr ? 1 : 0;
    fill_delay = int'($urandom_range(0, 6)); fill_words = ROW_WORDS;
    r = int'($urandom_range(0, 255)); s = 16'($urandom);
    salt = s; row_num = 8'(r);
    wr_addr = ADDR_W'($urandom); wr_data = 16'($urandom);
    wr_req = 1'b1; row_req = 1'b1;
    for (int c = 0; c < 400 && (wr_done < 2 || rd_done < 2); c++) begin
      step();
      if (wr_ack === 1'b1) begin
        wr_done++;
        if (wr_done < 2) begin
          wr_addr = ADDR_W'($urandom); wr_data = 16'($urandom);
        end else wr_req = 1'b0;
      end
      if (row_valid === 1'b1) begin
        rd_done++;
        nerr = 0;
        for (int k = 0; k < int'(ROW_WORDS); k++)
          if (row_data[k] !== exp_word(r, k, s)) nerr++;
        checks++;
        if (nerr != 0 || row_err !== 1'b0) begin
          failures++;
          $display("FAIL rr_row_data: %0d bad words err=%b for row %0d expected 0", nerr, row_err, r);
        end
        for (int k = 0; k < int'(ROW_WORDS); k++) exp_row[k] = exp_word(r, k, s);
        if (rd_done < 2) begin
          r = int'($urandom_range(0, 255)); s = 16'($urandom);
          salt = s; row_num = 8'(r);
        end else row_req = 1'b0;
      end
    end
    wr_req = 1'b0; row_req = 1'b0;
    repeat (10) step();
    last_was_wr = (grant_log.size() > 0) ? (grant_log[grant_log.size() - 1] == 0) : last_was_wr;
    checks++;
    if (wr_done != 2 || rd_done != 2 || grant_log.size() != 4) begin
      failures++;
      $display("FAIL rr_completion: wr=%0d rd=%0d grants=%0d expected 2 2 4",
               wr_done, rd_done, grant_log.size());
    end
    for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
      checks++;
      if (grant_log[i] != ((i % 2 == 0) ? first : 1 - first)) begin
        failures++;
        $display("FAIL rr_grant[%0d]: got %0d expected %0d (1=RD 0=WR)",
                 i, grant_log[i], (i % 2 == 0) ? first : 1 - first);
      end
    end
  endtask

  task automatic test_timeout();
    int lat;
    fetch_row(int'($urandom_range(0, 255)), 0, ROW_WORDS - 1, 16'($urandom), lat);
    checks++;
    if (lat < int'(TIMEOUT) || lat > int'(TIMEOUT) + 4) begin
      failures++;
      $display("FAIL timeout_latency: got %0d expected %0d..%0d", lat, TIMEOUT, TIMEOUT + 4);
    end
  endtask

  task automatic test_reset_mid_pop();
    int pops, v0, lat;
    fill_delay = 0; fill_words = ROW_WORDS; salt = 16'($urandom);
    row_num = 8'($urandom_range(0, 255));
    row_req = 1'b1;
    pops = 0;
    for (int c = 0; c < 60 && pops < 4; c++) begin
      step();
      if (sd_rd === 1'b1) pops++;
    end
    checks++;
    if (pops != 4) begin
      failures++;
      $display("FAIL mid_pop_reach: got %0d pops expected 4", pops);
    end
    v0 = n_valid;
    Reset = 1'b1;
    step();
    Reset = 1'b0; row_req = 1'b0;
    checks++;
    if ({sd_wr_load, sd_wr, sd_rd_load, sd_rd, wr_ack, row_valid, row_busy, row_err} !== 8'h00) begin
      failures++;
      $display("FAIL mid_pop_reset_strobes: got %b expected 00000000",
               {sd_wr_load, sd_wr, sd_rd_load, sd_rd, wr_ack, row_valid, row_busy, row_err});
    end
    repeat (20) step();
    checks++;
    if (n_valid != v0) begin
      failures++;
      $display("FAIL mid_pop_no_valid: got %0d row_valid pulses expected 0", n_valid - v0);
    end
    checks++;
    if (row_data !== '0) begin
      failures++;
      $display("FAIL mid_pop_row_data: got %0h expected 0 after reset", row_data);
    end
    for (int k = 0; k < int'(ROW_WORDS); k++) exp_row[k] = '0;
    last_was_wr = 1'b1;
    fetch_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 4)), ROW_WORDS, 16'($urandom), lat);
  endtask

  task automatic test_back_to_back();
    int lat;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(0, 1) == 0)
        do_write(ADDR_W'($urandom), 16'($urandom));
      else
        fetch_row(int'($urandom_range(0, 255)), int'($urandom_range(0, 8)),
                  ROW_WORDS, 16'($urandom), lat);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_row_fetch();
    test_write();
    test_round_robin();
    test_timeout();
    test_reset_mid_pop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
